// File: rtl/usb_axi_bridge.sv
// Bridges single-beat AXI-lite style reads and writes onto an 8-bit register
// bank (space 0) or a column-organised buffer memory (space 1).
module usb_axi_bridge #(
   parameter int ADDR_W         = 32,
   parameter int Data_W         = 32,
   parameter int MEM_ADDR_WIDTH = 6,
   parameter int MEM_NUM_COL    = 4,
   parameter int REG_ADDR_WIDTH = 6,
   parameter int TO_W           = 8
) (
   input  logic                      Clk_axi,
   input  logic                      Rst,
   input  logic                      R_Valid_Address,
   input  logic [ADDR_W-1:0]         Read_Address_axi,
   input  logic [2:0]                R_Prot,
   output logic                      R_Ready_Address,
   input  logic                      Write_Valid,
   input  logic [ADDR_W-1:0]         Write_Address_axi,
   input  logic [Data_W-1:0]         Write_Data_axi,
   input  logic [Data_W/8-1:0]       Write_Strobe,
   input  logic [2:0]                W_Prot,
   output logic                      Write_Ready,
   output logic                      W_Error,
   input  logic                      Read_Ready,
   output logic                      Valid_Data_R,
   output logic                      R_Error,
   output logic [Data_W-1:0]         Read_Data_axi,
   output logic [REG_ADDR_WIDTH-1:0] addr_reg,
   output logic [7:0]                data_reg,
   output logic                      wr_en_reg,
   output logic                      rd_en_reg,
   input  logic [7:0]                r_data_reg,
   input  logic                      data_reg_toggle,
   output logic                      mem_en,
   output logic [MEM_ADDR_WIDTH-1:0] addr_b,
   output logic [Data_W-1:0]         w_data_b,
   output logic [MEM_NUM_COL-1:0]    wr_en_mem,
   output logic [MEM_NUM_COL-1:0]    rd_en_mem,
   input  logic [Data_W-1:0]         r_data_mem,
   input  logic                      data_mem_toggle
);

   localparam int CW = $clog2(MEM_NUM_COL);
   // Last count value of the wait window: 2^TO_W-1 wait cycles, counter from 0
   localparam logic [TO_W-1:0] TO_LAST = ~(TO_W'(1));

   typedef enum logic [2:0] {
      IDLE, WR_ISSUE, WR_RESP, RD_ISSUE, RD_WAIT, RD_RESP
   } state_t;

   state_t                 state;
   logic                   last_grant_wr;
   logic                   rd_is_mem;
   logic                   rd_unmapped;
   logic                   toggle_sample;
   logic [TO_W-1:0]        to_cnt;

   logic                   grant_wr;
   logic                   grant_rd;
   logic [ADDR_W-1:0]      sel_addr;
   logic [ADDR_W-1:0]      word_idx;
   logic [ADDR_W-1:0]      col_idx;
   logic [ADDR_W-1:0]      row_idx;
   logic [3:0]             region;
   logic                   is_reg;
   logic                   is_mem;
   logic                   full_strobe;
   logic                   sel_toggle;
   logic [MEM_NUM_COL-1:0] col_onehot;
   logic                   unused_bits;

   // Decode the address of whichever request wins arbitration this cycle;
   // on a collision the type not granted last time wins.
   always_comb begin
      grant_wr    = Write_Valid && (!R_Valid_Address || !last_grant_wr);
      grant_rd    = R_Valid_Address && !grant_wr;
      sel_addr    = grant_wr ? Write_Address_axi : Read_Address_axi;
      region      = sel_addr[ADDR_W-1 -: 4];
      is_reg      = (region == 4'h0);
      is_mem      = (region == 4'h1);
      word_idx    = sel_addr >> 2;
      col_idx     = word_idx & ADDR_W'(MEM_NUM_COL - 1);
      row_idx     = word_idx >> CW;
      col_onehot  = MEM_NUM_COL'(1) << col_idx;
      full_strobe = &Write_Strobe;
      sel_toggle  = rd_is_mem ? data_mem_toggle : data_reg_toggle;
   end

   assign unused_bits = ^{R_Prot, W_Prot, sel_addr, word_idx, col_idx, row_idx};

   always_ff @(posedge Clk_axi) begin
      if (Rst) begin
         state           <= IDLE;
         last_grant_wr   <= 1'b0;
         rd_is_mem       <= 1'b0;
         rd_unmapped     <= 1'b0;
         toggle_sample   <= 1'b0;
         to_cnt          <= '0;
         R_Ready_Address <= 1'b0;
         Write_Ready     <= 1'b0;
         W_Error         <= 1'b0;
         Valid_Data_R    <= 1'b0;
         R_Error         <= 1'b0;
         Read_Data_axi   <= '0;
         addr_reg        <= '0;
         data_reg        <= '0;
         wr_en_reg       <= 1'b0;
         rd_en_reg       <= 1'b0;
         mem_en          <= 1'b0;
         addr_b          <= '0;
         w_data_b        <= '0;
         wr_en_mem       <= '0;
         rd_en_mem       <= '0;
      end else begin
         R_Ready_Address <= 1'b0;
         Write_Ready     <= 1'b0;
         wr_en_reg       <= 1'b0;
         rd_en_reg       <= 1'b0;
         mem_en          <= 1'b0;
         wr_en_mem       <= '0;
         rd_en_mem       <= '0;

         case (state)
            // Acceptance also launches the back-end strobes so they are
            // visible exactly while the FSM sits in the ISSUE state.
            IDLE: begin
               if (grant_wr) begin
                  Write_Ready   <= 1'b1;
                  last_grant_wr <= 1'b1;
                  W_Error       <= 1'b0;
                  state         <= WR_ISSUE;
                  if (is_reg) begin
                     addr_reg  <= word_idx[REG_ADDR_WIDTH-1:0];
                     data_reg  <= Write_Data_axi[7:0];
                     wr_en_reg <= Write_Strobe[0];
                  end else if (is_mem) begin
                     addr_b   <= row_idx[MEM_ADDR_WIDTH-1:0];
                     w_data_b <= Write_Data_axi;
                     if (full_strobe) begin
                        mem_en    <= 1'b1;
                        wr_en_mem <= col_onehot;
                     end else begin
                        W_Error <= 1'b1;
                     end
                  end else begin
                     W_Error <= 1'b1;
                  end
               end else if (grant_rd) begin
                  R_Ready_Address <= 1'b1;
                  last_grant_wr   <= 1'b0;
                  rd_is_mem       <= is_mem;
                  rd_unmapped     <= !is_reg && !is_mem;
                  state           <= RD_ISSUE;
                  if (is_reg) begin
                     addr_reg  <= word_idx[REG_ADDR_WIDTH-1:0];
                     rd_en_reg <= 1'b1;
                  end else if (is_mem) begin
                     addr_b    <= row_idx[MEM_ADDR_WIDTH-1:0];
                     mem_en    <= 1'b1;
                     rd_en_mem <= col_onehot;
                  end
               end
            end
            WR_ISSUE: state <= WR_RESP;
            WR_RESP:  state <= IDLE;
            RD_ISSUE: begin
               if (rd_unmapped) begin
                  Valid_Data_R  <= 1'b1;
                  R_Error       <= 1'b1;
                  Read_Data_axi <= '0;
                  state         <= RD_RESP;
               end else begin
                  toggle_sample <= sel_toggle;
                  to_cnt        <= '0;
                  state         <= RD_WAIT;
               end
            end
            // A toggle change wins over an expiring timeout in the same cycle.
            RD_WAIT: begin
               if (sel_toggle != toggle_sample) begin
                  Valid_Data_R  <= 1'b1;
                  R_Error       <= 1'b0;
                  Read_Data_axi <= rd_is_mem ? r_data_mem : Data_W'(r_data_reg);
                  to_cnt        <= '0;
                  state         <= RD_RESP;
               end else if (to_cnt == TO_LAST) begin
                  Valid_Data_R  <= 1'b1;
                  R_Error       <= 1'b1;
                  Read_Data_axi <= '0;
                  to_cnt        <= '0;
                  state         <= RD_RESP;
               end else begin
                  to_cnt <= to_cnt + 1'b1;
               end
            end
            RD_RESP: begin
               if (Read_Ready) begin
                  Valid_Data_R <= 1'b0;
                  state        <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_usb_axi_bridge.sv
// Directed and randomized transactions against usb_axi_bridge, checked with a
// transaction-level reference model of address decode, arbitration and timing.
module tb_usb_axi_bridge;

   localparam int TB_TO_W  = 4;
   localparam int WAIT_MAX = (1 << TB_TO_W) - 1;

   logic        Clk_axi;
   logic        Rst;
   logic        R_Valid_Address;
   logic [31:0] Read_Address_axi;
   logic [2:0]  R_Prot;
   logic        R_Ready_Address;
   logic        Write_Valid;
   logic [31:0] Write_Address_axi;
   logic [31:0] Write_Data_axi;
   logic [3:0]  Write_Strobe;
   logic [2:0]  W_Prot;
   logic        Write_Ready;
   logic        W_Error;
   logic        Read_Ready;
   logic        Valid_Data_R;
   logic        R_Error;
   logic [31:0] Read_Data_axi;
   logic [5:0]  addr_reg;
   logic [7:0]  data_reg;
   logic        wr_en_reg;
   logic        rd_en_reg;
   logic [7:0]  r_data_reg;
   logic        data_reg_toggle;
   logic        mem_en;
   logic [5:0]  addr_b;
   logic [31:0] w_data_b;
   logic [3:0]  wr_en_mem;
   logic [3:0]  rd_en_mem;
   logic [31:0] r_data_mem;
   logic        data_mem_toggle;

   int vectors = 0;
   int miscompares = 0;

   typedef struct packed {
      logic        reg_we;
      logic [5:0]  raddr;
      logic [7:0]  rdata;
      logic        mem_we;
      logic [3:0]  col;
      logic [5:0]  row;
      logic [31:0] mdata;
      logic        err;
   } wr_exp_t;

   usb_axi_bridge #(.TO_W(TB_TO_W)) dut (
      .Clk_axi(Clk_axi), .Rst(Rst),
      .R_Valid_Address(R_Valid_Address), .Read_Address_axi(Read_Address_axi),
      .R_Prot(R_Prot), .R_Ready_Address(R_Ready_Address),
      .Write_Valid(Write_Valid), .Write_Address_axi(Write_Address_axi),
      .Write_Data_axi(Write_Data_axi), .Write_Strobe(Write_Strobe),
      .W_Prot(W_Prot), .Write_Ready(Write_Ready), .W_Error(W_Error),
      .Read_Ready(Read_Ready), .Valid_Data_R(Valid_Data_R), .R_Error(R_Error),
      .Read_Data_axi(Read_Data_axi),
      .addr_reg(addr_reg), .data_reg(data_reg), .wr_en_reg(wr_en_reg),
      .rd_en_reg(rd_en_reg), .r_data_reg(r_data_reg),
      .data_reg_toggle(data_reg_toggle),
      .mem_en(mem_en), .addr_b(addr_b), .w_data_b(w_data_b),
      .wr_en_mem(wr_en_mem), .rd_en_mem(rd_en_mem), .r_data_mem(r_data_mem),
      .data_mem_toggle(data_mem_toggle)
   );

   initial Clk_axi = 1'b0;
   always #5 Clk_axi = ~Clk_axi;

   initial begin
      #400000;
      $display("[TB] FAIL watchdog expired before the sequence completed");
      $fatal(1, "[TB] watchdog");
   end

   task automatic tick();
      @(posedge Clk_axi);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [127:0] observed,
                              input logic [127:0] expected);
      vectors++;
      assert (observed === expected)
      else begin
         miscompares++;
         $error("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic wv, input logic [31:0] wa,
                                input logic [31:0] wd, input logic [3:0] ws,
                                input logic rv, input logic [31:0] ra);
      Write_Valid       = wv;
      Write_Address_axi = wa;
      Write_Data_axi    = wd;
      Write_Strobe      = ws;
      R_Valid_Address   = rv;
      Read_Address_axi  = ra;
      R_Prot            = 3'($urandom);
      W_Prot            = 3'($urandom);
   endtask

   task automatic doReset();
      applyStimulus(1'b0, '0, '0, '0, 1'b0, '0);
      Read_Ready = 1'b0;
      Rst = 1'b1;
      tick();
      Rst = 1'b0;
   endtask

   // Expected back-end effect of one write, from the address map alone.
   function automatic wr_exp_t modelWrite(logic [31:0] addr, logic [31:0] data,
                                          logic [3:0] strb);
      wr_exp_t     e;
      logic [31:0] space;
      logic [31:0] word;
      e     = '0;
      space = addr / 32'h1000_0000;
      word  = addr / 4;
      if (space == 0) begin
         e.reg_we = strb[0];
         e.raddr  = 6'(word % 64);
         e.rdata  = 8'(data % 256);
      end else if (space == 1) begin
         if (strb == 4'hF) begin
            e.mem_we = 1'b1;
            e.col    = 4'(1 << (word % 4));
            e.row    = 6'((word / 4) % 64);
            e.mdata  = data;
         end else begin
            e.err = 1'b1;
         end
      end else begin
         e.err = 1'b1;
      end
      return e;
   endfunction

   task automatic writeTxn(input string tag, input logic [31:0] addr,
                           input logic [31:0] data, input logic [3:0] strb);
      wr_exp_t e;
      int      lat;
      e = modelWrite(addr, data, strb);
      applyStimulus(1'b1, addr, data, strb, 1'b0, '0);
      lat = 0;
      while (!Write_Ready && lat < 8) begin
         tick();
         lat++;
      end
      checkOutput({tag, " accept latency"}, lat, 1);
      checkOutput({tag, " wr_en_reg"}, wr_en_reg, e.reg_we);
      if (e.reg_we) begin
         checkOutput({tag, " addr_reg"}, addr_reg, e.raddr);
         checkOutput({tag, " data_reg"}, data_reg, e.rdata);
      end
      checkOutput({tag, " mem_en/wr_en_mem"}, {mem_en, wr_en_mem}, {e.mem_we, e.col});
      if (e.mem_we) begin
         checkOutput({tag, " addr_b"}, addr_b, e.row);
         checkOutput({tag, " w_data_b"}, w_data_b, e.mdata);
      end
      checkOutput({tag, " read side idle"}, {R_Ready_Address, rd_en_reg, rd_en_mem}, 0);
      checkOutput({tag, " W_Error"}, W_Error, e.err);
      tick();
      applyStimulus(1'b0, '0, '0, '0, 1'b0, '0);
      checkOutput({tag, " strobes cleared"},
                  {Write_Ready, wr_en_reg, mem_en, wr_en_mem, rd_en_reg, rd_en_mem}, 0);
      checkOutput({tag, " W_Error held"}, W_Error, e.err);
      tick();
   endtask

   // Back end flips its toggle d cycles after the read strobe is seen.
   task automatic readTxn(input string tag, input logic [31:0] addr,
                          input int d, input int hold);
      logic [31:0] space;
      logic [31:0] word;
      logic [31:0] exp_data;
      logic [7:0]  rv8;
      logic [31:0] rv32;
      logic        mapped;
      logic        exp_err;
      int          lat;
      int          exp_lat;
      space   = addr / 32'h1000_0000;
      word    = addr / 4;
      mapped  = (space == 0) || (space == 1);
      rv8     = 8'($urandom);
      rv32    = $urandom;
      exp_err = !mapped || (d > WAIT_MAX);
      exp_data = exp_err ? 32'h0 : ((space == 0) ? {24'h0, rv8} : rv32);
      exp_lat  = !mapped ? 1 : (((d > WAIT_MAX) ? WAIT_MAX : d) + 1);

      applyStimulus(1'b0, '0, '0, '0, 1'b1, addr);
      lat = 0;
      while (!R_Ready_Address && lat < 8) begin
         tick();
         lat++;
      end
      checkOutput({tag, " accept latency"}, lat, 1);
      checkOutput({tag, " rd_en_reg"}, rd_en_reg, space == 0);
      checkOutput({tag, " mem_en/rd_en_mem"}, {mem_en, rd_en_mem},
                  (space == 1) ? {1'b1, 4'(1 << (word % 4))} : 5'b0);
      if (space == 0) checkOutput({tag, " addr_reg"}, addr_reg, 6'(word % 64));
      if (space == 1) checkOutput({tag, " addr_b"}, addr_b, 6'((word / 4) % 64));
      checkOutput({tag, " write side idle"}, {Write_Ready, wr_en_reg, wr_en_mem}, 0);

      lat = 0;
      for (int i = 1; i <= 40; i++) begin
         tick();
         if (i == 1) R_Valid_Address = 1'b0;
         if (mapped && i == d) begin
            r_data_reg = rv8;
            r_data_mem = rv32;
            if (space == 1) data_mem_toggle = ~data_mem_toggle;
            else            data_reg_toggle = ~data_reg_toggle;
         end
         if (Valid_Data_R) begin
            lat = i;
            break;
         end
      end
      checkOutput({tag, " response latency"}, lat, exp_lat);
      checkOutput({tag, " R_Error"}, R_Error, exp_err);
      checkOutput({tag, " Read_Data_axi"}, Read_Data_axi, exp_data);
      for (int i = 0; i < hold; i++) begin
         tick();
         checkOutput({tag, " held response"}, {Valid_Data_R, R_Error, Read_Data_axi},
                     {1'b1, exp_err, exp_data});
      end
      Read_Ready = 1'b1;
      tick();
      Read_Ready = 1'b0;
      checkOutput({tag, " valid dropped"}, Valid_Data_R, 1'b0);
   endtask

   initial begin
      logic [31:0] a;
      logic [3:0]  s;
      logic [3:0]  nib;
      $display("[TB] usb_axi_bridge bench starting");
      data_reg_toggle = 1'b0;
      data_mem_toggle = 1'b0;
      r_data_reg      = '0;
      r_data_mem      = '0;
      doReset();
      tick();
      checkOutput("reset outputs",
                  {R_Ready_Address, Write_Ready, W_Error, Valid_Data_R, R_Error,
                   Read_Data_axi, addr_reg, data_reg, wr_en_reg, rd_en_reg, mem_en,
                   addr_b, w_data_b, wr_en_mem, rd_en_mem}, 0);

      writeTxn("reg write", 32'h0000_0008, 32'h0000_00A5, 4'h1);
      writeTxn("mem write", 32'h1000_0034, 32'hDEAD_BEEF, 4'hF);
      writeTxn("reg write no strobe0", 32'h0000_0010, 32'h0000_0077, 4'h2);
      writeTxn("mem partial strobe", 32'h1000_0008, 32'h1111_2222, 4'h7);
      writeTxn("unmapped write", 32'hF000_0000, 32'h3333_4444, 4'hF);
      readTxn("mem read slow", 32'h1000_0000, 5, 4);
      readTxn("reg read timeout", 32'h0000_0004, 1000, 1);
      readTxn("reg read last-cycle toggle", 32'h0000_0008, WAIT_MAX, 1);
      readTxn("mem read one late", 32'h1000_0004, WAIT_MAX + 1, 0);
      readTxn("reg read fast", 32'h0000_00FC, 1, 2);
      readTxn("unmapped read", 32'h3000_0010, 3, 2);

      // Collisions right after reset: write first, then read.
      doReset();
      applyStimulus(1'b1, 32'h0000_0010, 32'h0000_005A, 4'h1, 1'b1, 32'h1000_0008);
      tick();
      checkOutput("collision1 grant", {Write_Ready, R_Ready_Address, wr_en_reg}, 3'b101);
      tick();
      applyStimulus(1'b1, 32'h0000_0014, 32'h0000_003C, 4'h1, 1'b1, 32'h1000_0008);
      tick();
      tick();
      checkOutput("collision2 grant", {Write_Ready, R_Ready_Address, mem_en, rd_en_mem},
                  {3'b011, 4'b0100});
      tick();
      R_Valid_Address = 1'b0;
      r_data_mem      = 32'hCAFE_0001;
      data_mem_toggle = ~data_mem_toggle;
      tick();
      checkOutput("collision read data", {Valid_Data_R, R_Error, Read_Data_axi},
                  {2'b10, 32'hCAFE_0001});
      Read_Ready = 1'b1;
      tick();
      Read_Ready = 1'b0;
      tick();
      checkOutput("pending write served", {Write_Ready, wr_en_reg, addr_reg, data_reg},
                  {2'b11, 6'd5, 8'h3C});
      tick();
      applyStimulus(1'b0, '0, '0, '0, 1'b0, '0);
      tick();

      // Reset in the middle of a read wait: no response may follow.
      writeTxn("unmapped write pre-reset", 32'h2000_0000, 32'h1234_5678, 4'hF);
      applyStimulus(1'b0, '0, '0, '0, 1'b1, 32'h0000_000C);
      tick();
      tick();
      R_Valid_Address = 1'b0;
      tick();
      Rst = 1'b1;
      tick();
      Rst = 1'b0;
      checkOutput("mid-read reset outputs",
                  {R_Ready_Address, Write_Ready, W_Error, Valid_Data_R, R_Error,
                   Read_Data_axi, addr_reg, data_reg, wr_en_reg, rd_en_reg, mem_en,
                   addr_b, w_data_b, wr_en_mem, rd_en_mem}, 0);
      data_reg_toggle = ~data_reg_toggle;
      for (int i = 0; i < 20; i++) tick();
      checkOutput("aborted read silent", {Valid_Data_R, R_Error}, 0);
      writeTxn("write after reset", 32'h0000_0020, 32'h0000_0099, 4'hF);

      // Randomized traffic across all address spaces.
      for (int n = 0; n < 40; n++) begin
         case ($urandom_range(0, 3))
            0:       nib = 4'h0;
            1:       nib = 4'h1;
            2:       nib = 4'h2;
            default: nib = 4'hF;
         endcase
         a = {nib, 28'($urandom)};
         if ($urandom_range(0, 1) == 0) begin
            s = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'hF;
            writeTxn("rand write", a, $urandom, s);
         end else begin
            readTxn("rand read", a, $urandom_range(1, 18), $urandom_range(0, 3));
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
